load_store_unit: RTL and testbench

// - Memory stage directly downstream of the execute unit. Consumes mem_req_t (load/store/addr/mask/wdata) and op_t.
// - Runs one blocking req/gnt/rvalid transaction on the data bus.
// - Returns byte-lane-aligned, sign/zero-extended load data for GPR/FPR writeback; reports bus faults.

---
 rtl/load_store_unit.sv | 269 ++++++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory stage that sits directly downstream of the execute unit. It accepts
// one load or store at a time, runs a single blocking req/gnt/rvalid
// transaction on the data bus, and retires it with a one-cycle wb_valid pulse
// that carries lane-aligned, sign/zero-extended load data for GPR/FPR
// writeback, or a load/store access fault.
//
// Ports
//   clk          clock, single domain
//   rst          asynchronous, active-low reset
//   flush        pipeline flush; kills the in-flight op
//   op           micro-op; selects extension and writeback target
//   mem_req      load/store/addr/mask/wdata from execute, sampled in IDLE
//   lsu_busy     stall upstream; high in REQ, RESP and DRAIN
//   bus_req      bus request (registered)
//   bus_we       1 = store
//   bus_addr     word-aligned address {addr[31:2], 2'b00}
//   bus_be       byte enables (mem_req.mask)
//   bus_wdata    store data, already lane-aligned upstream
//   bus_gnt      request accepted this cycle
//   bus_rvalid   response (load data or store ack)
//   bus_rdata    load data
//   bus_err      error qualifier on bus_rvalid
//   wb_valid     one-cycle pulse: transaction retired
//   wb_is_fpr    result targets the FPR file (OP_FLWS)
//   wb_data      extended load result; 0 for stores and faults
//   load_fault   load access fault, qualified by wb_valid
//   store_fault  store access fault, qualified by wb_valid
//
// Configuration
//   LSU_TIMEOUT_EN  when defined, enables a response watchdog of
//                   TIMEOUT_CYCLES cycles: a RESP that waits that long
//                   retires as a fault and moves to DRAIN to swallow the late
//                   rvalid; a DRAIN that waits that long returns to IDLE.
//                   When undefined, RESP and DRAIN wait for rvalid forever
//                   and TIMEOUT_CYCLES is unused.
// -----------------------------------------------------------------------------

package lsu_pkg;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_LB,
    OP_LBU,
    OP_LH,
    OP_LHU,
    OP_LW,
    OP_FLWS,
    OP_SB,
    OP_SH,
    OP_SW
  } op_t;

  typedef struct packed {
    logic        load;
    logic        store;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  op_t         op,
  input  mem_req_t    mem_req,
  output logic        lsu_busy,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err,
  output logic        wb_valid,
  output logic        wb_is_fpr,
  output logic [31:0] wb_data,
  output logic        load_fault,
  output logic        store_fault
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic        retire;
  logic        fault;
  logic        timeout_hit;

  // Attributes of the in-flight transaction, captured on accept.
  op_t         op_q;
  logic [1:0]  addr_lo_q;
  logic        is_store_q;

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  // ---------------------------------------------------------------------------
  // Response watchdog
  // ---------------------------------------------------------------------------
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] to_cnt_q;

  // Clears on every state change, so it restarts on entry to RESP and DRAIN;
  // the hit decodes the TIMEOUT_CYCLES-th cycle spent in that state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_q <= '0;
    end else if (state_d != state_q) begin
      to_cnt_q <= '0;
    end else if (state_q == RESP || state_q == DRAIN) begin
      to_cnt_q <= to_cnt_q + CW'(1);
    end
  end

  assign timeout_hit = (state_q == RESP || state_q == DRAIN) && (to_cnt_q == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    retire  = 1'b0;
    fault   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((mem_req.load || mem_req.store) && !flush) begin
          state_d = REQ;
          accept  = 1'b1;
        end
      end
      REQ: begin
        // Once granted, the slave owes a response: a flush in the grant cycle
        // still has to drain it.
        if (bus_gnt) begin
          state_d = flush ? DRAIN : RESP;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      RESP: begin
        if (flush) begin
          state_d = bus_rvalid ? IDLE : DRAIN;
        end else if (bus_rvalid) begin
          state_d = IDLE;
          retire  = 1'b1;
          fault   = bus_err;
        end else if (timeout_hit) begin
          state_d = DRAIN;
          retire  = 1'b1;
          fault   = 1'b1;
        end
      end
      DRAIN: begin
        if (bus_rvalid || timeout_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign lsu_busy = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // Request capture and bus drive; fields stay put until the next accept.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      op_q       <= OP_NOP;
      addr_lo_q  <= '0;
      is_store_q <= 1'b0;
    end else if (accept) begin
      bus_req    <= 1'b1;
      bus_we     <= mem_req.store;
      bus_addr   <= {mem_req.addr[31:2], 2'b00};
      bus_be     <= mem_req.mask;
      bus_wdata  <= mem_req.wdata;
      op_q       <= op;
      addr_lo_q  <= mem_req.addr[1:0];
      is_store_q <= mem_req.store;
    end else if (state_q == REQ && (bus_gnt || flush)) begin
      bus_req    <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    unique case (addr_lo_q)
      2'd0:    rd_byte = bus_rdata[7:0];
      2'd1:    rd_byte = bus_rdata[15:8];
      2'd2:    rd_byte = bus_rdata[23:16];
      default: rd_byte = bus_rdata[31:24];
    endcase
    rd_half = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    case (op_q)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'd0, rd_byte};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'd0, rd_half};
      default: load_data = bus_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Writeback: registered one cycle after the retiring response.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid    <= 1'b0;
      wb_is_fpr   <= 1'b0;
      wb_data     <= '0;
      load_fault  <= 1'b0;
      store_fault <= 1'b0;
    end else begin
      wb_valid    <= retire;
      wb_is_fpr   <= retire && (op_q == OP_FLWS);
      wb_data     <= (retire && !fault && !is_store_q) ? load_data : '0;
      load_fault  <= retire && fault && !is_store_q;
      store_fault <= retire && fault && is_store_q;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. Inputs change and outputs are sampled
// on the falling clock edge, half a cycle away from the active edge.
// -----------------------------------------------------------------------------

module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  op_t         op;
  mem_req_t    mem_req;
  logic        lsu_busy;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        wb_valid;
  logic        wb_is_fpr;
  logic [31:0] wb_data;
  logic        load_fault;
  logic        store_fault;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .op          (op),
    .mem_req     (mem_req),
    .lsu_busy    (lsu_busy),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_gnt     (bus_gnt),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .bus_err     (bus_err),
    .wb_valid    (wb_valid),
    .wb_is_fpr   (wb_is_fpr),
    .wb_data     (wb_data),
    .load_fault  (load_fault),
    .store_fault (store_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction, entered and left on a falling edge with the DUT
  // in IDLE. gnt_wait extra REQ cycles precede the grant, rv_wait extra RESP
  // cycles precede rvalid. Returns on the wb_valid cycle with mem_req cleared,
  // so a following call issues back-to-back.
  task automatic do_txn(input string name, input op_t o, input logic is_st,
                        input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] wdata, input int gnt_wait,
                        input int rv_wait, input logic [31:0] rdata,
                        input logic err, input logic [31:0] exp_data,
                        input logic exp_fpr);
    op      = o;
    mem_req = '{load: !is_st, store: is_st, addr: addr, mask: mask, wdata: wdata};
    @(negedge clk);
    for (int i = 0; i <= gnt_wait; i++) begin
      check({name, ":bus_req"},   32'(bus_req),  32'd1);
      check({name, ":bus_addr"},  bus_addr,      {addr[31:2], 2'b00});
      check({name, ":bus_be"},    32'(bus_be),   32'(mask));
      check({name, ":bus_we"},    32'(bus_we),   32'(is_st));
      check({name, ":bus_wdata"}, bus_wdata,     wdata);
      check({name, ":busy_req"},  32'(lsu_busy), 32'd1);
      check({name, ":wb_idle"},   32'(wb_valid), 32'd0);
      bus_gnt = (i == gnt_wait);
      @(negedge clk);
    end
    bus_gnt = 1'b0;
    for (int i = 0; i <= rv_wait; i++) begin
      check({name, ":req_drop"},  32'(bus_req),  32'd0);
      check({name, ":busy_resp"}, 32'(lsu_busy), 32'd1);
      check({name, ":wb_wait"},   32'(wb_valid), 32'd0);
      bus_rvalid = (i == rv_wait);
      bus_rdata  = rdata;
      bus_err    = err;
      @(negedge clk);
    end
    bus_rvalid = 1'b0;
    bus_err    = 1'b0;
    bus_rdata  = '0;
    op         = OP_NOP;
    mem_req    = '0;
    check({name, ":wb_valid"},    32'(wb_valid),    32'd1);
    check({name, ":wb_data"},     wb_data,          exp_data);
    check({name, ":wb_is_fpr"},   32'(wb_is_fpr),   32'(exp_fpr));
    check({name, ":load_fault"},  32'(load_fault),  32'(err && !is_st));
    check({name, ":store_fault"}, 32'(store_fault), 32'(err && is_st));
    check({name, ":busy_done"},   32'(lsu_busy),    32'd0);
  endtask

  // Issue a load and walk it to the first RESP cycle with an immediate grant.
  task automatic start_to_resp(input logic [31:0] addr);
    op      = OP_LW;
    mem_req = '{load: 1'b1, store: 1'b0, addr: addr, mask: 4'hF, wdata: 32'd0};
    @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    op      = OP_NOP;
    mem_req = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    flush      = 1'b0;
    op         = OP_NOP;
    mem_req    = '0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    bus_err    = 1'b0;

    repeat (3) @(negedge clk);
    check("rst:bus_req",  32'(bus_req),  32'd0);
    check("rst:lsu_busy", 32'(lsu_busy), 32'd0);
    check("rst:bus_addr", bus_addr,      32'd0);
    check("rst:wb_valid", 32'(wb_valid), 32'd0);
    check("rst:wb_data",  wb_data,       32'd0);
    check("rst:faults",   32'({load_fault, store_fault}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Load extraction, minimum latency and back-to-back issue.
    do_txn("lb_3",  OP_LB,   1'b0, 32'h0000_1003, 4'b1000, 32'd0, 0, 0, 32'h80FF_0000, 1'b0, 32'hFFFF_FF80, 1'b0);
    do_txn("lhu_2", OP_LHU,  1'b0, 32'h0000_2002, 4'b1100, 32'd0, 0, 0, 32'h8001_1234, 1'b0, 32'h0000_8001, 1'b0);
    do_txn("lh_0",  OP_LH,   1'b0, 32'h0000_2000, 4'b0011, 32'd0, 0, 0, 32'h8001_1234, 1'b0, 32'h0000_1234, 1'b0);
    do_txn("lbu_1", OP_LBU,  1'b0, 32'h0000_3001, 4'b0010, 32'd0, 1, 0, 32'h0000_8000, 1'b0, 32'h0000_0080, 1'b0);
    do_txn("lb_2",  OP_LB,   1'b0, 32'h0000_3002, 4'b0100, 32'd0, 0, 1, 32'h007F_0000, 1'b0, 32'h0000_007F, 1'b0);
    do_txn("lh_2",  OP_LH,   1'b0, 32'h0000_3006, 4'b1100, 32'd0, 0, 0, 32'hFFFE_0000, 1'b0, 32'hFFFF_FFFE, 1'b0);
    do_txn("lw",    OP_LW,   1'b0, 32'h0000_4004, 4'b1111, 32'd0, 0, 2, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0);
    do_txn("flws",  OP_FLWS, 1'b0, 32'h0000_5010, 4'b1111, 32'd0, 4, 0, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b1);

    // Stores and bus errors.
    do_txn("sw_err", OP_SW, 1'b1, 32'h0000_6008, 4'b1111, 32'hDEAD_BEEF, 0, 0, 32'h1111_1111, 1'b1, 32'd0, 1'b0);
    do_txn("lw_err", OP_LW, 1'b0, 32'h0000_600C, 4'b1111, 32'd0,         0, 0, 32'h2222_2222, 1'b1, 32'd0, 1'b0);
    do_txn("sb",     OP_SB, 1'b1, 32'h0000_7001, 4'b0010, 32'h0000_AB00, 0, 0, 32'h3333_3333, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    check("post_txn:wb_valid", 32'(wb_valid), 32'd0);

    // Flush in REQ, then flush in IDLE with a request present.
    op      = OP_LW;
    mem_req = '{load: 1'b1, store: 1'b0, addr: 32'h0000_8000, mask: 4'hF, wdata: 32'd0};
    @(negedge clk);
    check("fl_req:bus_req", 32'(bus_req), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    check("fl_req:busy",     32'(lsu_busy), 32'd0);
    check("fl_req:req_drop", 32'(bus_req),  32'd0);
    @(negedge clk);
    check("fl_idle:busy",    32'(lsu_busy), 32'd0);
    check("fl_idle:bus_req", 32'(bus_req),  32'd0);
    flush   = 1'b0;
    op      = OP_NOP;
    mem_req = '0;
    @(negedge clk);
    check("fl_req:wb_valid", 32'(wb_valid), 32'd0);

    // Flush in RESP drains the response without retiring it.
    start_to_resp(32'h0000_9000);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("drain:busy",     32'(lsu_busy), 32'd1);
      check("drain:wb_valid", 32'(wb_valid), 32'd0);
      @(negedge clk);
    end
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1234_5678;
    @(negedge clk);
    bus_rvalid = 1'b0;
    check("drain:busy_done", 32'(lsu_busy), 32'd0);
    check("drain:wb_done",   32'(wb_valid), 32'd0);
    @(negedge clk);
    check("drain:wb_after",  32'(wb_valid), 32'd0);

    // Flush in the same cycle as rvalid discards the result.
    start_to_resp(32'h0000_A000);
    flush      = 1'b1;
    bus_rvalid = 1'b1;
    @(negedge clk);
    flush      = 1'b0;
    bus_rvalid = 1'b0;
    check("fl_rv:busy",     32'(lsu_busy), 32'd0);
    check("fl_rv:wb_valid", 32'(wb_valid), 32'd0);

    // A stray rvalid in IDLE is ignored.
    bus_rvalid = 1'b1;
    @(negedge clk);
    bus_rvalid = 1'b0;
    check("idle_rv:wb_valid", 32'(wb_valid), 32'd0);
    check("idle_rv:busy",     32'(lsu_busy), 32'd0);

    // Normal traffic resumes after the flushes.
    do_txn("lw_after", OP_LW, 1'b0, 32'h0000_B000, 4'b1111, 32'd0, 0, 0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);

`ifdef LSU_TIMEOUT_EN
    // No rvalid for 8 RESP cycles: forced load fault, late rvalid swallowed.
    start_to_resp(32'h0000_C000);
    for (int i = 0; i < 8; i++) begin
      check("to:wb_wait", 32'(wb_valid), 32'd0);
      check("to:busy",    32'(lsu_busy), 32'd1);
      @(negedge clk);
    end
    check("to:wb_valid",   32'(wb_valid),   32'd1);
    check("to:load_fault", 32'(load_fault), 32'd1);
    check("to:wb_data",    wb_data,         32'd0);
    check("to:drain_busy", 32'(lsu_busy),   32'd1);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    bus_rvalid = 1'b0;
    check("to:late_wb", 32'(wb_valid), 32'd0);
    check("to:idle",    32'(lsu_busy), 32'd0);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
